sync_fifo_cfg: RTL and testbench
================================

SYNC_FIFO_CFG -- requirements
Module: sync_fifo_cfg

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, number of storage words; power of two, >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, width of each data word.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(FIFO_DEPTH), storage address width.
REQ-004 SHALL have parameter FWFT, default 1: 1 = first-word fall-through read, 0 = standard registered read.
REQ-005 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_flush  input  1  synchronous clear of FIFO contents.
REQ-008 SHALL have port i_valid_s  input  1  write request.
REQ-009 SHALL have port i_datain  input  DATA_WIDTH  write data.
REQ-010 SHALL have port o_ready_s  output  1  write accepted this cycle if i_valid_s is high.
REQ-011 SHALL have port i_ready_m  input  1  FWFT=1: pop acknowledge; FWFT=0: read strobe.
REQ-012 SHALL have port o_valid_m  output  1  o_dataout holds a valid word.
REQ-013 SHALL have port o_dataout  output  DATA_WIDTH  read data.
REQ-014 SHALL have ports i_almostfull_lvl and i_almostempty_lvl  input  ADDR_WIDTH+1  occupancy thresholds.
REQ-015 SHALL have ports o_full, o_empty, o_almostfull, o_almostempty  output  1 each  status flags.
REQ-016 SHALL have port o_count  output  ADDR_WIDTH+1  stored word count, 0..FIFO_DEPTH.
REQ-017 SHALL have port i_peak_clr  input  1  clear of peak-occupancy register.
REQ-018 SHALL have port o_peak  output  ADDR_WIDTH+1  highest o_count since reset or last i_peak_clr.

Function
REQ-019 Write SHALL be accepted when i_valid_s & o_ready_s; o_ready_s = !o_full; o_ready_s SHALL NOT depend on i_ready_m (no combinational read-to-write path).
REQ-020 Read accept: FWFT=1: i_ready_m & o_valid_m; FWFT=0: i_ready_m & !o_empty.
REQ-021 Pointers SHALL be ADDR_WIDTH+1 bits and wrap modulo 2*FIFO_DEPTH; storage indexed by low ADDR_WIDTH bits.
REQ-022 o_count SHALL be a register: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither.
REQ-023 o_full = (o_count == FIFO_DEPTH); o_empty = (o_count == 0); o_almostfull = (o_count >= i_almostfull_lvl); o_almostempty = (o_count <= i_almostempty_lvl); full-width unsigned compares.
REQ-024 FWFT=1: o_valid_m = !o_empty; o_dataout = head word, combinational from storage; write-to-o_valid_m latency 1 cycle.
REQ-025 FWFT=0: o_dataout SHALL register the popped word on the edge after an accepted read; o_valid_m SHALL pulse high exactly that cycle; o_dataout SHALL hold its last value otherwise.
REQ-026 FWFT=0: i_ready_m while empty SHALL be ignored (no pointer move, no o_valid_m).
REQ-027 Write when full SHALL be blocked even if a read is accepted the same cycle.
REQ-028 Data order SHALL be strict FIFO across any number of pointer wraps.
REQ-029 i_flush SHALL, next edge, zero pointers and o_count and clear o_valid_m; it overrides same-cycle write and read; storage and o_peak not cleared.
REQ-030 o_peak SHALL update each edge to max(o_peak, next o_count); i_peak_clr loads next o_count instead; i_peak_clr has priority over max.

Reset
REQ-031 i_rst high at a rising edge SHALL set pointers, o_count, o_peak, o_valid_m to 0 and FWFT=0 o_dataout to 0; hence o_empty=1, o_full=0, o_ready_s=1.
REQ-032 i_rst SHALL override i_flush, writes and reads, including mid-operation.
REQ-033 Storage array SHALL NOT be reset; FWFT=1 o_dataout is don't-care while o_valid_m=0.

Structure
REQ-034 Default FIFO_DEPTH/DATA_WIDTH constants SHALL live in the shared header sync_fifo_defines.vh, also used by the bench.
REQ-035 Storage SHALL be a sub-module sync_fifo_mem: simple dual-port, synchronous write, asynchronous read, no reset.
REQ-036 Control, count, flags and peak logic SHALL reside in sync_fifo_cfg.

Verification (FIFO_DEPTH=8, DATA_WIDTH=8)
REQ-037 FWFT=1, almostfull_lvl=6: write 0x01..0x08 back-to-back -> o_almostfull after 6th write, o_full/o_ready_s=0 and o_count=8 after 8th, 9th write blocked.
REQ-038 Drain previous -> o_dataout 0x01..0x08 in order, o_empty=1 after 8th pop, o_peak=8.
REQ-039 Stream 20 words with simultaneous write/read at o_count=4 -> o_count stays 4, order preserved across wrap.
REQ-040 FWFT=0: write 0xA5, strobe i_ready_m next cycle -> one cycle later o_valid_m=1 for one cycle, o_dataout=0xA5 and held.
REQ-041 o_count=5, i_flush with simultaneous write -> next cycle o_count=0, o_empty=1, o_peak=5; then i_peak_clr -> o_peak=0.
REQ-042 o_count=3, assert i_rst one cycle -> all outputs at reset values next edge; subsequent write 0x3C reads back 0x3C.

Source files
------------

// File: rtl/sync_fifo_cfg_pkg.sv
// sync_fifo_cfg_pkg
//   Shared constants and small helpers for the configurable synchronous FIFO.
//   Default depth/width come from sync_fifo_defines.vh so that every user of
//   the FIFO agrees on one set of numbers.
package sync_fifo_cfg_pkg;

`include "sync_fifo_defines.vh"

  localparam int SF_DEF_DEPTH = `SYNC_FIFO_DEF_DEPTH;
  localparam int SF_DEF_WIDTH = `SYNC_FIFO_DEF_WIDTH;

  // What the occupancy counter does on a given edge.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // A simultaneous write and read leave the count unchanged.
  function automatic cnt_op_e cnt_op(input logic wr, input logic rd);
    cnt_op_e op;
    op = CNT_HOLD;
    if (wr && !rd) op = CNT_INC;
    else if (rd && !wr) op = CNT_DEC;
    return op;
  endfunction

endpackage

// File: rtl/sync_fifo_defines.vh
// Shared default geometry for the configurable synchronous FIFO.
// Pulled into sync_fifo_cfg_pkg; the design and the bench see these
// values through the package constants SF_DEF_DEPTH / SF_DEF_WIDTH.
`ifndef SYNC_FIFO_DEFINES_VH
`define SYNC_FIFO_DEFINES_VH

`define SYNC_FIFO_DEF_DEPTH 16
`define SYNC_FIFO_DEF_WIDTH 8

`endif

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem
//   Simple dual-port storage for sync_fifo_cfg: one synchronous write port,
//   one asynchronous read port. Deliberately has no reset so it maps onto
//   distributed RAM / register-file macros.
// Ports
//   i_clk    : write clock (rising edge)
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data, combinational from i_raddr
module sync_fifo_mem
  import sync_fifo_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = SF_DEF_WIDTH,
  parameter int ADDR_WIDTH = $clog2(SF_DEF_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/sync_fifo_cfg.sv
// sync_fifo_cfg
//   Single-clock FIFO with selectable read mode, programmable almost-full /
//   almost-empty thresholds, flush and a peak-occupancy tracker.
//   FWFT=1 : head word is presented combinationally; o_valid_m = !o_empty and
//            i_ready_m pops it.
//   FWFT=0 : i_ready_m is a read strobe; the popped word is registered on the
//            following edge with a one-cycle o_valid_m pulse, then held.
// Ports
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_flush               : empty the FIFO (storage and peak untouched)
//   i_valid_s, i_datain   : write request / data
//   o_ready_s             : write side may accept (= !o_full)
//   i_ready_m             : pop acknowledge (FWFT=1) or read strobe (FWFT=0)
//   o_valid_m, o_dataout  : read side valid / data
//   i_almostfull_lvl      : o_almostfull  when o_count >= level
//   i_almostempty_lvl     : o_almostempty when o_count <= level
//   o_full, o_empty       : status flags from the registered count
//   o_count               : stored words, 0..FIFO_DEPTH
//   i_peak_clr, o_peak    : peak-occupancy clear / value
module sync_fifo_cfg
  import sync_fifo_cfg_pkg::*;
#(
  parameter int FIFO_DEPTH = SF_DEF_DEPTH,
  parameter int DATA_WIDTH = SF_DEF_WIDTH,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int FWFT       = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_valid_s,
  input  logic [DATA_WIDTH-1:0] i_datain,
  output logic                  o_ready_s,
  input  logic                  i_ready_m,
  output logic                  o_valid_m,
  output logic [DATA_WIDTH-1:0] o_dataout,
  input  logic [ADDR_WIDTH:0]   i_almostfull_lvl,
  input  logic [ADDR_WIDTH:0]   i_almostempty_lvl,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almostfull,
  output logic                  o_almostempty,
  output logic [ADDR_WIDTH:0]   o_count,
  input  logic                  i_peak_clr,
  output logic [ADDR_WIDTH:0]   o_peak
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  // Pointers carry one extra bit and wrap modulo 2*FIFO_DEPTH; only the low
  // bits address storage. Occupancy is tracked by a separate counter.
  logic [ADDR_WIDTH:0]   wr_ptr_q;
  logic [ADDR_WIDTH:0]   rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic [ADDR_WIDTH:0]   peak_q;
  logic [ADDR_WIDTH:0]   peak_nxt;
  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic                  rd_en;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  // Write acceptance looks only at registered state, so there is no
  // combinational path from the read side into o_ready_s. A full FIFO
  // refuses a write even if a read frees a slot on the same edge.
  assign wr_en = i_valid_s & ~full;

  // In both modes a read is accepted only when something is stored
  // (for FWFT=1, o_valid_m is exactly !empty).
  assign rd_en = i_ready_m & ~empty;

  assign mem_we = wr_en & ~i_flush & ~i_rst;

  always_comb begin
    count_nxt = count_q;
    if (i_flush) begin
      count_nxt = '0;
    end else begin
      case (cnt_op(wr_en, rd_en))
        CNT_INC: count_nxt = count_q + 1'b1;
        CNT_DEC: count_nxt = count_q - 1'b1;
        default: count_nxt = count_q;
      endcase
    end
  end

  // Peak follows the count that is about to be registered, so a clear
  // during traffic starts from the true new occupancy rather than zero.
  always_comb begin
    peak_nxt = peak_q;
    if (i_peak_clr) begin
      peak_nxt = count_nxt;
    end else if (count_nxt > peak_q) begin
      peak_nxt = count_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      peak_q   <= '0;
    end else begin
      if (i_flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_nxt;
      peak_q  <= peak_nxt;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .i_wdata (i_datain),
    .i_raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .o_rdata (mem_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word straight from storage; meaningless while empty.
      assign o_valid_m = ~empty;
      assign o_dataout = mem_rdata;
    end else begin : g_std
      logic                  rd_valid_q;
      logic [DATA_WIDTH-1:0] rd_data_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
        end else if (i_flush) begin
          // Flush cancels a same-cycle read; the last word stays visible.
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_en;
          if (rd_en) rd_data_q <= mem_rdata;
        end
      end

      assign o_valid_m = rd_valid_q;
      assign o_dataout = rd_data_q;
    end
  endgenerate

  assign o_ready_s     = ~full;
  assign o_full        = full;
  assign o_empty       = empty;
  assign o_almostfull  = (count_q >= i_almostfull_lvl);
  assign o_almostempty = (count_q <= i_almostempty_lvl);
  assign o_count       = count_q;
  assign o_peak        = peak_q;

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Bench for sync_fifo_cfg: one FWFT=1 and one FWFT=0 instance share the
// same stimulus. A queue-based model predicts occupancy, flags, peak and the
// registered read port; a negedge process compares both instances each cycle,
// and the directed sequence adds literal expectations.
module tb_sync_fifo_cfg;
  import sync_fifo_cfg_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = SF_DEF_WIDTH;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst, flush, valid_s, ready_m, peak_clr;
  logic [DW-1:0] datain;
  logic [AW:0]   af_lvl, ae_lvl;

  logic          a_ready, a_valid, a_full, a_empty, a_af, a_ae;
  logic [DW-1:0] a_dout;
  logic [AW:0]   a_count, a_peak;
  logic          b_ready, b_valid, b_full, b_empty, b_af, b_ae;
  logic [DW-1:0] b_dout;
  logic [AW:0]   b_count, b_peak;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_cfg #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid_s(valid_s), .i_datain(datain),
    .o_ready_s(a_ready), .i_ready_m(ready_m), .o_valid_m(a_valid), .o_dataout(a_dout),
    .i_almostfull_lvl(af_lvl), .i_almostempty_lvl(ae_lvl), .o_full(a_full), .o_empty(a_empty),
    .o_almostfull(a_af), .o_almostempty(a_ae), .o_count(a_count), .i_peak_clr(peak_clr),
    .o_peak(a_peak));

  sync_fifo_cfg #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid_s(valid_s), .i_datain(datain),
    .o_ready_s(b_ready), .i_ready_m(ready_m), .o_valid_m(b_valid), .o_dataout(b_dout),
    .i_almostfull_lvl(af_lvl), .i_almostempty_lvl(ae_lvl), .o_full(b_full), .o_empty(b_empty),
    .o_almostfull(b_af), .o_almostempty(b_ae), .o_count(b_count), .i_peak_clr(peak_clr),
    .o_peak(b_peak));

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [DW-1:0] q[$];
  int            m_peak;
  logic          m_v0;
  logic [DW-1:0] m_d0;
  bit            m_wr, m_rd;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_peak = 0;
      m_v0   = 1'b0;
      m_d0   = '0;
    end else begin
      m_wr = valid_s && (q.size() < DEPTH);
      m_rd = ready_m && (q.size() > 0);
      if (flush) begin
        q.delete();
        m_v0 = 1'b0;
      end else begin
        m_v0 = m_rd;
        if (m_rd) m_d0 = q.pop_front();
        if (m_wr) q.push_back(datain);
      end
      if (peak_clr) m_peak = q.size();
      else if (q.size() > m_peak) m_peak = q.size();
    end
  end

  int n;
  always @(negedge clk) begin
    if (chk_en) begin
      n = q.size();
      chk("a_count", int'(a_count), n);
      chk("b_count", int'(b_count), n);
      chk("a_full",  int'(a_full),  int'(n == DEPTH));
      chk("b_full",  int'(b_full),  int'(n == DEPTH));
      chk("a_empty", int'(a_empty), int'(n == 0));
      chk("b_empty", int'(b_empty), int'(n == 0));
      chk("a_ready", int'(a_ready), int'(n < DEPTH));
      chk("b_ready", int'(b_ready), int'(n < DEPTH));
      chk("a_af",    int'(a_af),    int'(n >= int'(af_lvl)));
      chk("b_af",    int'(b_af),    int'(n >= int'(af_lvl)));
      chk("a_ae",    int'(a_ae),    int'(n <= int'(ae_lvl)));
      chk("b_ae",    int'(b_ae),    int'(n <= int'(ae_lvl)));
      chk("a_peak",  int'(a_peak),  m_peak);
      chk("b_peak",  int'(b_peak),  m_peak);
      chk("a_valid", int'(a_valid), int'(n > 0));
      if (n > 0) chk("a_dout", int'(a_dout), int'(q[0]));
      chk("b_valid", int'(b_valid), int'(m_v0));
      chk("b_dout",  int'(b_dout),  int'(m_d0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic v, input logic [DW-1:0] d, input logic r,
                      input logic fl = 1'b0, input logic pc = 1'b0, input logic rs = 1'b0);
    valid_s = v; datain = d; ready_m = r; flush = fl; peak_clr = pc; rst = rs;
    @(posedge clk); #1;
    valid_s = 1'b0; ready_m = 1'b0; flush = 1'b0; peak_clr = 1'b0; rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; valid_s = 1'b0; ready_m = 1'b0; peak_clr = 1'b0;
    datain = '0; af_lvl = 4'd6; ae_lvl = 4'd2;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // reset state
    chk("rst_count", int'(a_count), 0);
    chk("rst_empty", int'(a_empty), 1);
    chk("rst_full",  int'(a_full),  0);
    chk("rst_ready", int'(a_ready), 1);
    chk("rst_peak",  int'(a_peak),  0);
    chk("rst_bval",  int'(b_valid), 0);
    chk("rst_bdout", int'(b_dout),  0);

    // fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, DW'(i), 1'b0);
      if (i == 5) chk("af_after5", int'(a_af), 0);
      if (i == 6) chk("af_after6", int'(a_af), 1);
    end
    chk("full_after8",  int'(a_full),  1);
    chk("ready_after8", int'(a_ready), 0);
    chk("count_after8", int'(a_count), 8);
    tick(1'b1, 8'h99, 1'b0);
    chk("blocked_count", int'(a_count), 8);
    chk("blocked_head",  int'(a_dout),  8'h01);
    // full with simultaneous read: write still refused
    tick(1'b1, 8'hEE, 1'b1);
    chk("fullrw_count", int'(a_count), 7);
    chk("fullrw_bdout", int'(b_dout),  8'h01);
    chk("fullrw_bval",  int'(b_valid), 1);

    // drain
    for (int i = 2; i <= 8; i++) begin
      chk("drain_head", int'(a_dout), i);
      tick(1'b0, 8'h00, 1'b1);
      chk("drain_bdout", int'(b_dout), i);
    end
    chk("drain_empty", int'(a_empty), 1);
    chk("drain_peak",  int'(a_peak),  8);

    // steady streaming at occupancy 4 across pointer wraps
    for (int i = 0; i < 4; i++) tick(1'b1, DW'(8'h10 + i), 1'b0);
    for (int k = 0; k < 20; k++) begin
      chk("stream_head", int'(a_dout), 8'h10 + k);
      tick(1'b1, DW'(8'h14 + k), 1'b1);
      chk("stream_count", int'(a_count), 4);
    end
    for (int k = 0; k < 4; k++) begin
      chk("tail_head", int'(a_dout), 8'h24 + k);
      tick(1'b0, 8'h00, 1'b1);
    end

    // standard-mode strobe while empty is ignored
    tick(1'b0, 8'h00, 1'b1);
    chk("emptyrd_bval",  int'(b_valid), 0);
    chk("emptyrd_bdout", int'(b_dout),  8'h27);
    chk("emptyrd_count", int'(b_count), 0);

    // registered read of 0xA5
    tick(1'b1, 8'hA5, 1'b0);
    chk("a5_aval", int'(a_valid), 1);
    chk("a5_bval_pre", int'(b_valid), 0);
    tick(1'b0, 8'h00, 1'b1);
    chk("a5_bval",  int'(b_valid), 1);
    chk("a5_bdout", int'(b_dout),  8'hA5);
    tick(1'b0, 8'h00, 1'b0);
    chk("a5_bval_drop", int'(b_valid), 0);
    chk("a5_bdout_hold", int'(b_dout), 8'hA5);

    // peak clear, fill 5, flush with write, clear peak again
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("pclr0_peak", int'(a_peak), 0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, DW'(8'h50 + i), 1'b0);
      if (i == 1) chk("ae_at2", int'(a_ae), 1);
      if (i == 2) chk("ae_at3", int'(a_ae), 0);
    end
    chk("pre_flush_count", int'(a_count), 5);
    tick(1'b1, 8'h77, 1'b0, 1'b1);
    chk("flush_count", int'(a_count), 0);
    chk("flush_empty", int'(a_empty), 1);
    chk("flush_peak",  int'(a_peak),  5);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("pclr_peak", int'(a_peak), 0);

    // reset mid-operation with write and read asserted
    for (int i = 0; i < 3; i++) tick(1'b1, DW'(8'h31 + i), 1'b0);
    chk("pre_rst_count", int'(a_count), 3);
    tick(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mrst_count", int'(a_count), 0);
    chk("mrst_empty", int'(a_empty), 1);
    chk("mrst_full",  int'(a_full),  0);
    chk("mrst_ready", int'(a_ready), 1);
    chk("mrst_peak",  int'(a_peak),  0);
    chk("mrst_bval",  int'(b_valid), 0);
    chk("mrst_bdout", int'(b_dout),  0);
    tick(1'b1, 8'h3C, 1'b0);
    chk("post_rst_head", int'(a_dout), 8'h3C);
    tick(1'b0, 8'h00, 1'b1);
    chk("post_rst_bdout", int'(b_dout), 8'h3C);
    chk("post_rst_bval",  int'(b_valid), 1);

    tick(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
